fifo_ptr_ctrl: RTL
==================

// Module: fifo_ptr_ctrl
// PURPOSE
//   Read/write pointer controller for the synchronous FIFO, directly upstream of the
//   pointer comparator. Accepts write/read requests and maintains wrap-extended pointers.
//   Drives the comparator's pointer inputs and the RAM addresses.
//   Produces registered full/empty flags, accept strobes and overflow/underflow pulses.
// PARAMETERS
//   ADDR_W   3   RAM address width; depth = 2**ADDR_W; pointer width = ADDR_W+1 (=4, comparator K)
// PORTS
//   clk        in   1         clock, rising edge
//   rst_n      in   1         asynchronous reset, active low
//   wr_en      in   1         write request
//   rd_en      in   1         read request
//   wr_ptr     out  ADDR_W+1  write pointer, MSB = wrap bit (to comparator A)
//   rd_ptr     out  ADDR_W+1  read pointer, MSB = wrap bit (to comparator B)
//   wr_addr    out  ADDR_W    wr_ptr[ADDR_W-1:0], RAM write address
//   rd_addr    out  ADDR_W    rd_ptr[ADDR_W-1:0], RAM read address
//   wr_ack     out  1         write accepted this cycle (combinational: wr_en & ~full)
//   rd_ack     out  1         read accepted this cycle (combinational: rd_en & ~empty)
//   full       out  1         registered; FIFO holds 2**ADDR_W entries
//   empty      out  1         registered; FIFO holds 0 entries
//   overflow   out  1         registered 1-cycle pulse: wr_en while full
//   underflow  out  1         registered 1-cycle pulse: rd_en while empty
// BEHAVIOUR
//   - Reset (async, rst_n=0): wr_ptr=rd_ptr=0, empty=1, full=0, overflow=underflow=0.
//     Reset mid-operation discards all contents; the first edge after release behaves as empty.
//   - Handshake: the RAM writes at wr_addr when wr_ack=1; read data is addressed by rd_addr when rd_ack=1.
//   - On wr_ack, wr_ptr <= wr_ptr+1 mod 2**(ADDR_W+1). On rd_ack, rd_ptr increments the same way.
//     The MSB toggles on each address wrap (7->0 at ADDR_W=3).
//   - Flags are computed from next-state pointers and registered together with the pointers.
//     No added latency; flags are valid in the same cycle as the new pointers.
//     empty_nxt = (wr_nxt == rd_nxt)
//     full_nxt  = (wr_nxt[ADDR_W] != rd_nxt[ADDR_W]) && (wr_nxt[ADDR_W-1:0] == rd_nxt[ADDR_W-1:0])
//   - Simultaneous wr_en & rd_en:
//       neither full nor empty -> both pointers advance; flags unchanged.
//       full  -> read accepted; write rejected; overflow pulses; full clears next cycle.
//       empty -> write accepted; read rejected; underflow pulses; empty clears next cycle.
//   - Rejected requests never move a pointer. overflow/underflow are 1-cycle pulses.
//     They are high for each cycle the offending request persists.
// CONFIGURATION
//   FIFO_LEVEL_EN defined: adds port level out ADDR_W+1, registered occupancy.
//     level = wr_nxt - rd_nxt (mod 2**(ADDR_W+1)), range 0..2**ADDR_W; reset 0.
//     level==2**ADDR_W iff full; level==0 iff empty.
//   Not defined: port and logic absent; all other behaviour identical.
// STRUCTURE
//   Shared package/header fifo_pkg: ADDR_W default, PTR_W=ADDR_W+1, DEPTH=2**ADDR_W.
//   One sub-module: fifo_ptr_cnt (PTR_W-bit enable-gated wrapping counter).
//     Instantiated twice, once for write and once for read.
//   Flag logic stays local to fifo_ptr_ctrl.
// TESTING
//   1 reset: drive rst_n=0 mid-stream with ptrs at 5/2 -> immediate ptrs 0, empty=1, full=0, pulses 0.
//   2 fill: 8 writes from empty -> wr_ptr 0..8 (4'b1000), full=1 after 8th edge, rd_ptr=0; 9th write -> overflow=1, wr_ptr stays 8.
//   3 drain: 8 reads from full -> rd_ptr=8, empty=1; extra read -> underflow=1, rd_ptr stays 8.
//   4 wrap: 12 writes interleaved with 12 reads -> ptrs cross 7->8->12; empty on equality only; full never set.
//   5 simultaneous: wr_en=rd_en=1 at full -> only rd_ptr advances, full=0 next; at empty -> only wr_ptr advances, empty=0 next.
//   6 FIFO_LEVEL_EN: random 500-cycle traffic -> level equals scoreboard count every cycle; full/empty match level 8/0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing constants for the synchronous FIFO pointer logic.
package fifo_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

endpackage : fifo_pkg

// File: rtl/fifo_ptr_cnt.sv
// Enable-gated wrapping pointer counter; exposes both current and next-state value.
module fifo_ptr_cnt #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [Width-1:0] cnt,
    output logic [Width-1:0] cnt_nxt
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;

endmodule : fifo_ptr_cnt

// File: rtl/fifo_ptr_ctrl.sv
// FIFO read/write pointer controller with registered full/empty and overflow/underflow pulses.
// Optional FIFO_LEVEL_EN adds a registered occupancy output `level`.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = fifo_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [ADDR_W:0]   wr_ptr,
    output logic [ADDR_W:0]   rd_ptr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_ack,
    output logic              rd_ack,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
`ifdef FIFO_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level
`endif
);

    logic [ADDR_W:0] wr_nxt, rd_nxt;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    assign wr_ack = wr_en & ~full_q;
    assign rd_ack = rd_en & ~empty_q;

    fifo_ptr_cnt #(
        .Width (ADDR_W + 1)
    ) u_wr_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (wr_ack),
        .cnt     (wr_ptr),
        .cnt_nxt (wr_nxt)
    );

    fifo_ptr_cnt #(
        .Width (ADDR_W + 1)
    ) u_rd_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (rd_ack),
        .cnt     (rd_ptr),
        .cnt_nxt (rd_nxt)
    );

    // Flags come from next-state pointers so they land in the same cycle as the pointers.
    always_comb begin
        empty_d     = (wr_nxt == rd_nxt);
        full_d      = (wr_nxt[ADDR_W] != rd_nxt[ADDR_W]) &&
                      (wr_nxt[ADDR_W-1:0] == rd_nxt[ADDR_W-1:0]);
        overflow_d  = wr_en & full_q;
        underflow_d = rd_en & empty_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef FIFO_LEVEL_EN
    logic [ADDR_W:0] level_q, level_d;

    always_comb begin
        level_d = wr_nxt - rd_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

    assign wr_addr   = wr_ptr[ADDR_W-1:0];
    assign rd_addr   = rd_ptr[ADDR_W-1:0];
    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule : fifo_ptr_ctrl
